// File: rtl/warp_lsu_pkg.sv
// Shared types for the warp load-store unit: data/address widths, scheduler and LSU state encodings.
package warp_lsu_pkg;

  typedef logic [31:0] data_t;

  localparam int unsigned ADDR_W = 8;
  typedef logic [ADDR_W-1:0] data_memory_address_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  // Base + offset wraps at 32 bits, then keeps only the memory address bits.
  function automatic data_memory_address_t lane_addr(input data_t base, input data_t off);
    data_t sum;
    sum = base + off;
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/warp_lsu_lane_picker.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest active lane and an any flag.
module lsu_lane_picker
  #(parameter int unsigned THREADS = 4,
    parameter int unsigned IDX_W   = 2)
  (
    input  logic [THREADS-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               any
  );

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (mask[i] && !any) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_lsu.sv
// Warp-wide load-store unit: serialises active lanes' LDR/STR onto one data-memory port.
// Optional build macro LSU_COALESCE_EN merges pending lanes that share an address.
module warp_lsu
  import warp_lsu_pkg::*;
  #(parameter int unsigned THREADS = 4)
  (
    input  logic                           clk,
    input  logic                           reset,
    input  warp_state_t                    warp_state,
    input  logic [THREADS-1:0]             thread_mask,
    input  logic                           decoded_mem_read_enable,
    input  logic                           decoded_mem_write_enable,
    input  data_t [THREADS-1:0]            rs1,
    input  data_t [THREADS-1:0]            rs2,
    input  data_t [THREADS-1:0]            imm,
    output logic                           mem_read_valid,
    output data_memory_address_t           mem_read_address,
    input  logic                           mem_read_ready,
    input  data_t                          mem_read_data,
    output logic                           mem_write_valid,
    output data_memory_address_t           mem_write_address,
    output data_t                          mem_write_data,
    input  logic                           mem_write_ready,
    output lsu_state_t                     lsu_state,
    output data_t [THREADS-1:0]            lsu_out
  );

  localparam int unsigned IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

  logic                 read_mode;
  data_memory_address_t addr_q [THREADS];
  data_t                data_q [THREADS];
  logic [THREADS-1:0]   pending;
  logic [THREADS-1:0]   match_q;
  logic [THREADS-1:0]   match_req;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  data_t                wdata_req;

  lsu_lane_picker #(.THREADS(THREADS), .IDX_W(IDX_W)) u_picker (
    .mask (pending),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Lanes retired by the transaction being issued; registered so WAITING clears exactly these.
  always_comb begin
    match_req = '0;
    wdata_req = data_q[pick_idx];
`ifdef LSU_COALESCE_EN
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (pending[i] && (addr_q[i] == addr_q[pick_idx])) begin
        match_req[i] = 1'b1;
        wdata_req    = data_q[i];
      end
    end
`else
    match_req[pick_idx] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_state         <= LSU_IDLE;
      read_mode         <= 1'b0;
      pending           <= '0;
      match_q           <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
      for (int unsigned i = 0; i < THREADS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (lsu_state)
        LSU_IDLE: begin
          if (warp_state == WARP_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            read_mode <= decoded_mem_read_enable;
            pending   <= thread_mask;
            for (int unsigned i = 0; i < THREADS; i++) begin
              addr_q[i] <= lane_addr(rs1[i], imm[i]);
              data_q[i] <= rs2[i];
            end
            lsu_state <= (thread_mask == '0) ? LSU_DONE : LSU_REQUESTING;
          end
        end
        LSU_REQUESTING: begin
          if (!pick_any) begin
            lsu_state <= LSU_DONE;
          end else begin
            match_q <= match_req;
            if (read_mode) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= addr_q[pick_idx];
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= addr_q[pick_idx];
              mem_write_data    <= wdata_req;
            end
            lsu_state <= LSU_WAITING;
          end
        end
        LSU_WAITING: begin
          if (read_mode ? mem_read_ready : mem_write_ready) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            if (read_mode) begin
              for (int unsigned i = 0; i < THREADS; i++) begin
                if (match_q[i]) lsu_out[i] <= mem_read_data;
              end
            end
            pending   <= pending & ~match_q;
            lsu_state <= ((pending & ~match_q) != '0) ? LSU_REQUESTING : LSU_DONE;
          end
        end
        LSU_DONE: begin
          if (warp_state == WARP_UPDATE) lsu_state <= LSU_IDLE;
        end
        default: lsu_state <= LSU_IDLE;
      endcase
    end
  end

endmodule
